seg7_scan_driver: RTL and testbench

//  Consumer end of the display digit-rotation interface. Generates its own scan

---
 rtl/seg7_scan_driver.sv | 133 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// 8-digit common-anode 7-segment scan driver, frame-aligned double buffer; LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Latency: pins registered one cycle after idx/disp/blank; a load reaches the pins after the next frame boundary.
// Backpressure: none; load is a strobe and the last load before a boundary wins.
module seg7_scan_driver #(
    parameter int TICK_DIV = 50000,
    parameter int PW       = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] data_in_i,
    input  logic [7:0]  dp_in_i,
    input  logic        blank_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        pending_o,
    output logic        frame_done_o
);

    typedef struct packed {
        logic [31:0] val;
        logic [7:0]  dp;
    } frame_t;

    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    frame_t        stage_q, stage_d;
    frame_t        disp_q, disp_d;
    logic          pending_q, pending_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          tick;
    logic          boundary;
    logic          slot_blank;
    logic [7:0]    lz_mask;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic run;
    // A slot is a leading zero when it and every slot above it are zero with no decimal point.
    always_comb begin
        lz_mask = '0;
        run     = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            run        = run & (disp_q.val[4*k +: 4] == 4'h0) & ~disp_q.dp[k];
            lz_mask[k] = run;
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        tick         = (presc_q == TICK_MAX);
        boundary     = tick && (idx_q == 3'd7);
        presc_d      = tick ? '0 : presc_q + 1'b1;
        idx_d        = tick ? idx_q + 3'd1 : idx_q;

        stage_d      = stage_q;
        if (load_i) begin
            stage_d.val = data_in_i;
            stage_d.dp  = dp_in_i;
        end
        // Boundary copies the pre-load staging value; a coincident load waits for the next frame.
        disp_d       = boundary ? stage_q : disp_q;
        pending_d    = load_i | (pending_q & ~boundary);
        frame_done_d = boundary;

        slot_blank   = blank_i | lz_mask[idx_q];
        an_d         = slot_blank ? 8'hFF : ~(8'b1 << idx_q);
        seg_d        = slot_blank ? 7'h7F : hex7(disp_q.val[4*idx_q +: 4]);
        dp_d         = slot_blank ? 1'b1 : ~disp_q.dp[idx_q];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q      <= '0;
            idx_q        <= '0;
            stage_q      <= '0;
            disp_q       <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            stage_q      <= stage_d;
            disp_q       <= disp_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an_o         = an_q;
    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign pending_o    = pending_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: per-edge reference model feeds a scoreboard queue, a separate monitor compares.
module tb_seg7_scan_driver;

    localparam int TD    = 4;
    localparam int FRAME = 8 * TD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  dpin = '0;
    logic        blank = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        pending;
    logic        frame_done;

    seg7_scan_driver #(.TICK_DIV(TD), .PW(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_i       (load),
        .data_in_i    (data),
        .dp_in_i      (dpin),
        .blank_i      (blank),
        .an_o         (an),
        .seg_o        (seg),
        .dp_o         (dp),
        .pending_o    (pending),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       pending;
        logic       frame_done;
    } obs_t;

    obs_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          edge_n   = 0;
    logic [31:0] m_stage  = '0;
    logic [31:0] m_disp   = '0;
    logic [7:0]  m_dps    = '0;
    logic [7:0]  m_dpd    = '0;
    logic        m_pend   = 1'b0;
    logic [6:0]  HEX [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference: slot and frame position follow from the edge count since reset release.
    function automatic obs_t model_step(input logic ld, input logic [31:0] d,
                                        input logic [7:0] p, input logic bl);
        obs_t e;
        int   idx;
        logic bnd;
        logic off;
        idx = (edge_n / TD) % 8;
        bnd = (edge_n % FRAME) == (FRAME - 1);
        off = bl;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && (m_disp >> (4 * idx)) == 32'd0 && (m_dpd >> idx) == 8'd0)
            off = 1'b1;
`endif
        e.an  = off ? 8'hFF : 8'hFF - (8'd1 << idx);
        e.seg = off ? 7'h7F : HEX[m_disp[4*idx +: 4]];
        e.dp  = off ? 1'b1 : !m_dpd[idx];
        if (bnd) begin
            m_disp = m_stage;
            m_dpd  = m_dps;
        end
        if (ld) begin
            m_stage = d;
            m_dps   = p;
            m_pend  = 1'b1;
        end else if (bnd) begin
            m_pend = 1'b0;
        end
        e.pending    = m_pend;
        e.frame_done = bnd;
        edge_n++;
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            edge_n  = 0;
            m_stage = '0;
            m_disp  = '0;
            m_dps   = '0;
            m_dpd   = '0;
            m_pend  = 1'b0;
            exp_q.delete();
        end else begin
            exp_q.push_back(model_step(load, data, dpin, blank));
        end
    end

    obs_t mon_exp;
    obs_t mon_got;
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            mon_got = {an, seg, dp, pending, frame_done};
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty got=%h", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                check("scan_out{an,seg,dp,pend,fd}", 32'(mon_got), 32'(mon_exp));
            end
        end
    end

    task automatic wait_slot(input int m);
        for (int i = 0; i <= FRAME; i++) begin
            if (edge_n % FRAME == m) return;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL wait_slot_timeout got=%0d exp=%0d", edge_n % FRAME, m);
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] p);
        load = 1'b1;
        data = d;
        dpin = p;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_an", 32'(an), 32'h FF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dp", 32'(dp), 32'h1);
        check("reset_pending", 32'(pending), 32'h0);
        check("reset_frame_done", 32'(frame_done), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("first_edge_an", 32'(an), 32'hFE);
        check("first_edge_seg", 32'(seg), 32'h01);
        repeat (40) @(negedge clk);

        wait_slot(10);
        do_load(32'h89ABCDEF, 8'h00);
        check("pending_after_load", 32'(pending), 32'h1);
        repeat (2 * FRAME) @(negedge clk);

        wait_slot(3);
        do_load(32'h11111111, 8'h00);
        repeat (5) @(negedge clk);
        do_load(32'h22222222, 8'h00);
        repeat (2 * FRAME) @(negedge clk);

        wait_slot(FRAME - 1);
        load = 1'b1;
        data = 32'h5A5A5A5A;
        dpin = 8'h81;
        @(posedge clk);
        #2;
        check("pending_across_boundary", 32'(pending), 32'h1);
        check("frame_done_on_load_boundary", 32'(frame_done), 32'h1);
        @(negedge clk);
        load = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        wait_slot(13);
        blank = 1'b1;
        repeat (10) @(negedge clk);
        blank = 1'b0;
        repeat (FRAME) @(negedge clk);

        do_load(32'h00000305, 8'h00);
        repeat (3 * FRAME) @(negedge clk);

        wait_slot(9);
        do_load(32'hDEADBEEF, 8'hFF);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_an", 32'(an), 32'hFF);
        check("midreset_seg", 32'(seg), 32'h7F);
        check("midreset_pending", 32'(pending), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        for (int c = 0; c < 1500; c++) begin
            load = ($urandom_range(0, 19) == 0);
            data = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> ($urandom_range(0, 7) * 4));
            dpin = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 59) == 0) blank = ~blank;
            @(negedge clk);
        end
        load  = 1'b0;
        blank = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
